// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit 1, DATA_W bits LSB-first, optional even parity, stop bit 0.
// Optional parity stage is enabled by defining SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef SIPO_FRAME_RX_PARITY_EN
    PARITY = 2'd3,
`endif
    STOP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              good;
  logic              load;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic              par_bit_q, par_bit_d;
  logic              parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    good         = 1'b0;
    load         = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (din) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        shreg_d[bit_cnt_q] = din;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef SIPO_FRAME_RX_PARITY_EN
      PARITY: begin
        par_bit_d = din;
        state_d   = STOP;
      end
`endif
      STOP: begin
        // The stop bit only closes the frame; a new start must come on a later edge.
        state_d = IDLE;
        if (din) begin
          frame_err_d = 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
        end else if (^{shreg_q, par_bit_q}) begin
          parity_err_d = 1'b1;
`endif
        end else begin
          good = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume on the same edge frees the holding register for the new word.
    load      = good && (!dout_valid_q || dout_ready);
    overrun_d = good && !load;
    if (load) begin
      dout_d       = shreg_q;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (DATA_W=8); parity steps run when SIPO_FRAME_RX_PARITY_EN is defined.
module tb_sipo_frame_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_frame_rx #(.DATA_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit, let one rising edge pass, then settle 1 time unit.
  task automatic step(input logic d, input logic r);
    din        = d;
    dout_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par,
                            input logic rdy_body, input logic rdy_stop, input string tag);
    step(1'b1, rdy_body);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) step(data[i], rdy_body);
`ifdef SIPO_FRAME_RX_PARITY_EN
    step(par, rdy_body);
`else
    if (par === 1'bx) n_checks = n_checks;
`endif
    step(stop_bit, rdy_stop);
  endtask

  initial begin
    reset      = 1'b1;
    din        = 1'b0;
    dout_ready = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_dout",       32'(dout),       32'h0);
    check("rst_valid",      32'(dout_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    reset = 1'b0;

    // Idle line for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      check("idle_busy_valid_errs", {28'd0, busy, dout_valid, frame_err, overrun}, 32'd0);
    end

    // Single frame 0xA5, then consume it.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "a5");
    check("a5_dout",      32'(dout),       32'hA5);
    check("a5_valid",     32'(dout_valid), 32'd1);
    check("a5_busy_done", 32'(busy),       32'd0);
    check("a5_no_errs",   {29'd0, frame_err, parity_err, overrun}, 32'd0);
    step(1'b0, 1'b1);
    check("a5_consumed",  32'(dout_valid), 32'd0);

    // Back-to-back 0x3C then 0xC3 with ready held high.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, "b2b1");
    check("b2b1_dout",  32'(dout),       32'h3C);
    check("b2b1_valid", 32'(dout_valid), 32'd1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, "b2b2");
    check("b2b2_dout",  32'(dout),       32'hC3);
    check("b2b2_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b1);
    check("b2b2_consumed", 32'(dout_valid), 32'd0);

    // Frame error: stop bit 1; the stop bit must not start a new frame.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, "ferr");
    check("ferr_pulse", 32'(frame_err),  32'd1);
    check("ferr_valid", 32'(dout_valid), 32'd0);
    check("ferr_busy",  32'(busy),       32'd0);
    step(1'b0, 1'b0);
    check("ferr_pulse_end", 32'(frame_err), 32'd0);
    check("ferr_idle",      32'(busy),      32'd0);

    // Overrun: 0x11 held while 0x22 arrives.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, "ovr1");
    check("ovr1_dout",    32'(dout),    32'h11);
    check("ovr1_overrun", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, "ovr2");
    check("ovr2_overrun", 32'(overrun),    32'd1);
    check("ovr2_dout",    32'(dout),       32'h11);
    check("ovr2_valid",   32'(dout_valid), 32'd1);
    step(1'b0, 1'b1);
    check("ovr_pulse_end", 32'(overrun),    32'd0);
    check("ovr_consumed",  32'(dout_valid), 32'd0);

    // Simultaneous consume and load at the stop edge.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, "sim1");
    check("sim1_dout", 32'(dout), 32'h5A);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, "sim2");
    check("sim2_dout",    32'(dout),       32'h96);
    check("sim2_valid",   32'(dout_valid), 32'd1);
    check("sim2_overrun", 32'(overrun),    32'd0);
    step(1'b0, 1'b1);
    check("sim2_consumed", 32'(dout_valid), 32'd0);

`ifdef SIPO_FRAME_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs parity bit 1.
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, "par_ok");
    check("par_ok_dout",  32'(dout),       32'h07);
    check("par_ok_valid", 32'(dout_valid), 32'd1);
    check("par_ok_err",   32'(parity_err), 32'd0);
    step(1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, "par_bad");
    check("par_bad_pulse", 32'(parity_err), 32'd1);
    check("par_bad_valid", 32'(dout_valid), 32'd0);
    step(1'b0, 1'b0);
    check("par_bad_pulse_end", 32'(parity_err), 32'd0);
`endif

    // Load a word, then reset mid-frame at data bit 4.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst");
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", {22'd0, dout, busy, dout_valid}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_rst_held", {22'd0, dout, busy, dout_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      check("post_rst_quiet", {28'd0, busy, frame_err, parity_err, overrun}, 32'd0);
    end
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst_dout",  32'(dout),       32'h81);
    check("post_rst_valid", 32'(dout_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the `siso` shift-register stage and consumes its `dout` bit stream. It samples one bit per `clock` edge and detects a start bit. It then assembles `DATA_W` data bits LSB-first, checks the stop bit (and the optional parity bit), and presents the word on a valid/ready output port backed by a one-entry holding register. Error conditions are reported as single-cycle pulses.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 2–32.
- `clock` input 1: the single clock; all sampling is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `din` input 1: serial line from the upstream `siso` `dout`; idle level 0.
- `dout` output `DATA_W`: received word, valid while `dout_valid`=1.
- `dout_valid` output 1: holding register contains an unconsumed word.
- `dout_ready` input 1: consumer accepts the word on any edge where `dout_valid`&&`dout_ready`.
- `busy` output 1: receiver is not in IDLE.
- `frame_err` output 1: one-cycle pulse when the stop bit is bad.
- `parity_err` output 1: one-cycle pulse when parity is bad; constant 0 when the parity feature is compiled out.
- `overrun` output 1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- Frame format on `din`: start bit = 1, then `DATA_W` data bits LSB-first, then [parity bit], then stop bit = 0. One bit is sampled per edge.
- FSM states: IDLE, DATA, PARITY (present only with the feature compiled in), STOP.
  - IDLE: `din`=1 → DATA with `bit_cnt`=0; `din`=0 → stay in IDLE.
  - DATA: `shreg[bit_cnt]` ← `din`, `bit_cnt`++. After bit `DATA_W`-1 is sampled → PARITY, or → STOP when parity is compiled out.
  - PARITY: latch `din` as `par_bit` → STOP.
  - STOP: always → IDLE. The stop bit is never reinterpreted as a new start bit.
- STOP evaluation, in priority order:
  - `din`=1 → `frame_err` pulse, word discarded.
  - Parity mismatch (^{`shreg`,`par_bit`} ≠ 0, even parity) → `parity_err` pulse, word discarded.
  - Otherwise the frame is good:
    - If `dout_valid`=0, or `dout_ready`=1 on the same edge, load `dout` ← `shreg` and set `dout_valid`=1.
    - Else pulse `overrun`; the old `dout` and `dout_valid` are kept unchanged.
- Handshake:
  - `dout_valid` falls on the edge where `dout_valid`&&`dout_ready` and no load occurs on that edge.
  - A simultaneous consume and load keeps `dout_valid`=1 and presents the new word.
  - `dout` is stable while `dout_valid`=1 and no transfer occurs.
- `bit_cnt` width is $clog2(`DATA_W`); its only terminal value is `DATA_W`-1, and it never wraps inside a frame.

## Timing
- Reset values (asynchronous): state=IDLE, `bit_cnt`=0, `shreg`=0, `dout`=0, `dout_valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, `overrun`=0.
- Reset mid-frame aborts the frame with no error pulse. Reception resumes at the first `din`=1 sampled after reset deasserts.
- Latency, counting the start bit sampled at edge 0:
  - Data is sampled at edges 1..`DATA_W`.
  - Parity is at edge `DATA_W`+1 when enabled.
  - Stop is at edge `DATA_W`+1 without parity, or `DATA_W`+2 with parity.
  - `dout_valid`, `dout`, and the error pulses update on the stop edge and are visible after it.
- `busy` = 1 from the edge after the start bit through the stop edge.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge.
- `dout_ready` is combinationally unused; the block has no input-to-output combinational paths.

## Configuration
- `SIPO_FRAME_RX_PARITY_EN` defined:
  - The PARITY state exists, and the frame is `DATA_W`+3 bits long.
  - Even parity is checked, and `parity_err` is driven.
- `SIPO_FRAME_RX_PARITY_EN` undefined:
  - No PARITY state, and the frame is `DATA_W`+2 bits long.
  - `parity_err` is tied to 0.

## Test plan
- Reset then idle: hold `din`=0 for 20 cycles → `busy`=0, `dout_valid`=0, no error pulses.
- Single frame 0xA5, no parity: `din`=1,1,0,1,0,0,1,0,1,0 → after the 10th edge `dout`=0xA5 and `dout_valid`=1. With `dout_ready`=1 one cycle later → `dout_valid`=0.
- Back-to-back frames 0x3C then 0xC3 with `dout_ready`=1 held: two `dout_valid` transfers, 10 cycles apart, with values 0x3C then 0xC3.
- Frame error: frame 0x55 with stop bit=1 → `frame_err` pulses for 1 cycle, `dout_valid` stays 0, FSM returns to IDLE.
- Overrun: `dout_ready`=0, frames 0x11 then 0x22 → `dout`=0x11 stays held, `overrun` pulses on the second stop edge. Then `dout_ready`=1 → 0x11 is consumed and `dout_valid`=0.
- Parity build (`SIPO_FRAME_RX_PARITY_EN`): 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → `parity_err` pulse and no load. `reset` asserted at data bit 4 → all outputs 0 immediately and no error pulse.
